// File: rtl/fmac_arbiter.sv
// Round-robin arbiter sharing one combinational fmac, with multicycle operand hold and result register.
// Optional sticky exception flags are built when FMAC_ARB_STICKY_FLAGS_EN is defined.
module fmac_arbiter #(
  parameter int C_NUM_REQ     = 2,
  parameter int C_ID_WIDTH    = 3,
  parameter int C_FMAC_CYCLES = 2,
  parameter int C_RM          = 2
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RI,
  input  logic [C_NUM_REQ-1:0]      Req_Valid_SI,
  output logic [C_NUM_REQ-1:0]      Req_Ready_SO,
  input  logic [32*C_NUM_REQ-1:0]   Req_Operand_a_DI,
  input  logic [32*C_NUM_REQ-1:0]   Req_Operand_b_DI,
  input  logic [32*C_NUM_REQ-1:0]   Req_Operand_c_DI,
  input  logic [C_RM*C_NUM_REQ-1:0] Req_RM_DI,
  output logic [31:0]               Fmac_Operand_a_DO,
  output logic [31:0]               Fmac_Operand_b_DO,
  output logic [31:0]               Fmac_Operand_c_DO,
  output logic [C_RM-1:0]           Fmac_RM_SO,
  input  logic [31:0]               Fmac_Result_DI,
  input  logic                      Fmac_OF_SI,
  input  logic                      Fmac_UF_SI,
  input  logic                      Fmac_NX_SI,
  output logic                      Out_Valid_SO,
  input  logic                      Out_Ready_SI,
  output logic [31:0]               Out_Result_DO,
  output logic [2:0]                Out_Flags_DO,
  output logic [C_ID_WIDTH-1:0]     Out_Id_DO,
  output logic                      Busy_SO
`ifdef FMAC_ARB_STICKY_FLAGS_EN
  ,
  input  logic                      Flags_Clr_SI,
  output logic [2:0]                Sticky_Flags_DO
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_r;
  logic [C_ID_WIDTH-1:0] ptr_r;
  logic [C_ID_WIDTH-1:0] id_r;
  logic [2:0]            cnt_r;

  logic                  found_s;
  logic [C_ID_WIDTH-1:0] winner_s;
  logic [C_ID_WIDTH-1:0] ptr_next_s;
  logic                  window_s;
  logic                  accept_s;
  logic                  capture_s;
  logic [C_NUM_REQ-1:0]  ready_s;
  logic [31:0]           sel_a_s;
  logic [31:0]           sel_b_s;
  logic [31:0]           sel_c_s;
  logic [C_RM-1:0]       sel_rm_s;
  logic [2:0]            flags_s;

  // Round-robin search: requesters at or above the pointer first, then wrap to the lower ones.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!found_s && Req_Valid_SI[i] && (i >= int'(ptr_r))) begin
        found_s  = 1'b1;
        winner_s = C_ID_WIDTH'(i);
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (!found_s && Req_Valid_SI[i] && (i < int'(ptr_r))) begin
        found_s  = 1'b1;
        winner_s = C_ID_WIDTH'(i);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Accept window, one-hot grant and operand selection of the winner.
  always_comb begin
    window_s = (state_r == IDLE) || ((state_r == HOLD) && Out_Ready_SI);
    accept_s = window_s && found_s && !Rst_RI;
    ready_s  = '0;
    sel_a_s  = 32'h0000_0000;
    sel_b_s  = 32'h0000_0000;
    sel_c_s  = 32'h0000_0000;
    sel_rm_s = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (winner_s == C_ID_WIDTH'(i)) begin
        ready_s[i] = accept_s;
        sel_a_s    = Req_Operand_a_DI[32*i +: 32];
        sel_b_s    = Req_Operand_b_DI[32*i +: 32];
        sel_c_s    = Req_Operand_c_DI[32*i +: 32];
        sel_rm_s   = Req_RM_DI[C_RM*i +: C_RM];
      end else begin
        ready_s[i] = 1'b0;
      end
    end
    if (winner_s == C_ID_WIDTH'(C_NUM_REQ-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + C_ID_WIDTH'(1);
    end
  end

  assign Req_Ready_SO = ready_s;
  assign Busy_SO      = (state_r != IDLE);
  assign capture_s    = (state_r == EXEC) && (cnt_r == 3'd0);
  assign flags_s      = {Fmac_OF_SI, Fmac_UF_SI, Fmac_NX_SI};

  // Control FSM with operand, result and id registers.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_r           <= IDLE;
      ptr_r             <= '0;
      id_r              <= '0;
      cnt_r             <= 3'd0;
      Fmac_Operand_a_DO <= 32'h0000_0000;
      Fmac_Operand_b_DO <= 32'h0000_0000;
      Fmac_Operand_c_DO <= 32'h0000_0000;
      Fmac_RM_SO        <= '0;
      Out_Valid_SO      <= 1'b0;
      Out_Result_DO     <= 32'h0000_0000;
      Out_Flags_DO      <= 3'b000;
      Out_Id_DO         <= '0;
    end else begin
      // Operands only move on an accept, keeping the fmac inputs frozen for the multicycle window.
      if (accept_s) begin
        Fmac_Operand_a_DO <= sel_a_s;
        Fmac_Operand_b_DO <= sel_b_s;
        Fmac_Operand_c_DO <= sel_c_s;
        Fmac_RM_SO        <= sel_rm_s;
        id_r              <= winner_s;
        ptr_r             <= ptr_next_s;
        cnt_r             <= 3'(C_FMAC_CYCLES - 1);
      end
      case (state_r)
        IDLE: begin
          state_r <= accept_s ? EXEC : IDLE;
        end
        EXEC: begin
          if (capture_s) begin
            Out_Result_DO <= Fmac_Result_DI;
            Out_Flags_DO  <= flags_s;
            Out_Id_DO     <= id_r;
            Out_Valid_SO  <= 1'b1;
            state_r       <= HOLD;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        HOLD: begin
          if (Out_Ready_SI) begin
            Out_Valid_SO <= 1'b0;
            state_r      <= accept_s ? EXEC : IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          Out_Valid_SO <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

`ifdef FMAC_ARB_STICKY_FLAGS_EN
  // Sticky flags: a coincident clear wipes the old value before the new flags are OR-ed in.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      Sticky_Flags_DO <= 3'b000;
    end else if (capture_s) begin
      Sticky_Flags_DO <= (Flags_Clr_SI ? 3'b000 : Sticky_Flags_DO) | flags_s;
    end else if (Flags_Clr_SI) begin
      Sticky_Flags_DO <= 3'b000;
    end else begin
      Sticky_Flags_DO <= Sticky_Flags_DO;
    end
  end
`endif

endmodule

// File: tb/tb_fmac_arbiter.sv
// Bench for fmac_arbiter: transaction-level reference model plus a stand-in fmac with known vectors.
module tb_fmac_arbiter;
  localparam int N   = 2;
  localparam int IDW = 3;
  localparam int CY  = 2;
  localparam int RMW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  op_a, op_b, op_c;
  logic [RMW*N-1:0] op_rm;
  logic [31:0]      fa, fb, fc;
  logic [RMW-1:0]   frm;
  logic [34:0]      mock;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [IDW-1:0]   out_id;
  logic             busy;
  logic             clr;
  logic [2:0]       sticky;

  // Stand-in fmac: exact results for the directed vectors, a scrambling function otherwise.
  function automatic logic [34:0] fmac_mock(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [1:0] rm);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4040_0000)
      return {3'b000, 32'h40E0_0000};
    else if (a == 32'h0000_0000 && b == 32'h7F7F_FFFF && c == 32'h4000_0000)
      return {3'b101, 32'h7F80_0000};
    else if (a == 32'h3F80_0000 && b == 32'h3380_0000 && c == 32'h3F80_0001)
      return {3'b001, 32'h3F80_0001};
    else
      return {a[2:0] ^ b[2:0] ^ c[2:0], a ^ (b << 1) ^ {c[15:0], c[31:16]} ^ {30'd0, rm}};
  endfunction

  assign mock = fmac_mock(fa, fb, fc, frm);

  fmac_arbiter #(.C_NUM_REQ(N), .C_ID_WIDTH(IDW), .C_FMAC_CYCLES(CY), .C_RM(RMW)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .Req_Valid_SI(req_valid), .Req_Ready_SO(req_ready),
    .Req_Operand_a_DI(op_a), .Req_Operand_b_DI(op_b), .Req_Operand_c_DI(op_c), .Req_RM_DI(op_rm),
    .Fmac_Operand_a_DO(fa), .Fmac_Operand_b_DO(fb), .Fmac_Operand_c_DO(fc), .Fmac_RM_SO(frm),
    .Fmac_Result_DI(mock[31:0]), .Fmac_OF_SI(mock[34]), .Fmac_UF_SI(mock[33]), .Fmac_NX_SI(mock[32]),
    .Out_Valid_SO(out_valid), .Out_Ready_SI(out_ready), .Out_Result_DO(out_result),
    .Out_Flags_DO(out_flags), .Out_Id_DO(out_id), .Busy_SO(busy)
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    , .Flags_Clr_SI(clr), .Sticky_Flags_DO(sticky)
`endif
  );
`ifndef FMAC_ARB_STICKY_FLAGS_EN
  assign sticky = 3'b000;
`endif

  // Reference model: an op in flight with edges remaining, and a held result slot.
  int          m_ptr, m_rem, m_id, o_id;
  bit          m_pend, m_ov;
  logic [31:0] m_a, m_b, m_c, o_res;
  logic [1:0]  m_rm;
  logic [2:0]  o_flg, m_sticky;

  int checks = 0;
  int errors = 0;
  int grants[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rem = 0; m_id = 0; o_id = 0; m_pend = 0; m_ov = 0;
    m_a = 0; m_b = 0; m_c = 0; m_rm = 0; o_res = 0; o_flg = 0; m_sticky = 0;
  endtask

  function automatic bit model_window();
    return !m_pend && (!m_ov || out_ready);
  endfunction

  task automatic model_step();
    int w;
    logic [34:0] r;
    bit cap;
    if (rst) begin
      model_reset();
      return;
    end
    w   = model_window() ? pick(req_valid, m_ptr) : -1;
    cap = m_pend && (m_rem == 1);
    if (m_pend) begin
      if (cap) begin
        r = fmac_mock(m_a, m_b, m_c, m_rm);
        o_res = r[31:0]; o_flg = r[34:32]; o_id = m_id;
        m_ov = 1; m_pend = 0;
      end else begin
        m_rem--;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (cap) m_sticky = (clr ? 3'b000 : m_sticky) | o_flg;
    else if (clr) m_sticky = 3'b000;
    if (w >= 0) begin
      m_a = op_a[32*w +: 32]; m_b = op_b[32*w +: 32]; m_c = op_c[32*w +: 32];
      m_rm = op_rm[RMW*w +: RMW]; m_id = w;
      m_ptr = (w + 1) % N; m_pend = 1; m_rem = CY;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] er;
    int w;
    er = '0;
    if (!rst && model_window()) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_pend || m_ov));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_result", out_result, o_res);
    chk("out_flags", 32'(out_flags), 32'(o_flg));
    chk("out_id", 32'(out_id), 32'(o_id));
    chk("fmac_a", fa, m_a);
    chk("fmac_b", fb, m_b);
    chk("fmac_c", fc, m_c);
    chk("fmac_rm", 32'(frm), 32'(m_rm));
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("sticky", 32'(sticky), 32'(m_sticky));
`endif
    if (!rst && req_ready != '0) grants.push_back(req_ready[1] ? 1 : 0);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [1:0] rm);
    op_a[32*i +: 32] = a; op_b[32*i +: 32] = b; op_c[32*i +: 32] = c;
    op_rm[RMW*i +: RMW] = rm;
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50 && busy; n++) tick();
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  logic [31:0] a1;

  initial begin
    rst = 1'b1; model_reset();
    req_valid = '0; op_a = '0; op_b = '0; op_c = '0; op_rm = '0;
    out_ready = 1'b1; clr = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single op from requester 0
    set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'd0);
    req_valid = 2'b01;
    #1 chk("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_fmac_a", fa, 32'h3F80_0000);
    tick();
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'h40E0_0000);
    chk("t1_flags", 32'(out_flags), 32'd0);
    chk("t1_id", 32'(out_id), 32'd0);

    // Reset during EXEC
    set_req(1, $urandom, $urandom, $urandom, 2'($urandom));
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    req_valid = 2'b11;
    rst = 1'b1; model_reset();
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_result", out_result, 32'd0);
    chk("t5_fmac_a", fa, 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = 2'b00;
    repeat (4) tick();
    chk("t5_no_valid", 32'(out_valid), 32'd0);

    // Both requesters continuously valid: alternate grants from pointer 0
    grants.delete();
    req_valid = 2'b11;
    for (int n = 0; n < 60 && grants.size() < 4; n++) begin
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      op_c = {$urandom, $urandom}; op_rm = 4'($urandom);
      tick();
    end
    req_valid = 2'b00;
    chk("t2_grant_count", 32'(grants.size() >= 4), 32'd1);
    if (grants.size() >= 4) begin
      chk("t2_grant0", 32'(grants[0]), 32'd0);
      chk("t2_grant1", 32'(grants[1]), 32'd1);
      chk("t2_grant2", 32'(grants[2]), 32'd0);
      chk("t2_grant3", 32'(grants[3]), 32'd1);
    end
    wait_idle();

    // Backpressure in HOLD with requester 1 waiting
    out_ready = 1'b0;
    set_req(0, $urandom, $urandom, $urandom, 2'd1);
    req_valid = 2'b01;
    tick();
    a1 = 32'hA5A5_0001;
    set_req(1, a1, $urandom, $urandom, 2'd2);
    req_valid = 2'b10;
    tick(); tick();
    repeat (5) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_ready_low", 32'(req_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t3_ready_win1", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    chk("t3_valid_cleared", 32'(out_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_fmac_a", fa, a1);
    wait_idle();

    // Overflow vector
    set_req(0, 32'h0000_0000, 32'h7F7F_FFFF, 32'h4000_0000, 2'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_valid();
    chk("t4_result", out_result, 32'h7F80_0000);
    chk("t4_flags", 32'(out_flags), 32'd5);
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("t4_sticky", 32'(sticky), 32'd5);
`endif
    repeat (3) tick();
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("t4_sticky_persist", 32'(sticky), 32'd5);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("t4_sticky_clr", 32'(sticky), 32'd0);
`endif

    // Prior OF-only sticky, then NX result captured on the same edge as a clear
    set_req(0, 32'h0000_0004, 32'h0, 32'h0, 2'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_valid();
    chk("t6_prior_flags", 32'(out_flags), 32'd4);
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("t6_prior_sticky", 32'(sticky), 32'd4);
`endif
    wait_idle();
    set_req(0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0001, 2'd0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_result", out_result, 32'h3F80_0001);
    chk("t6_flags", 32'(out_flags), 32'd1);
`ifdef FMAC_ARB_STICKY_FLAGS_EN
    chk("t6_sticky", 32'(sticky), 32'd1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; model_reset();
      end else begin
        rst = 1'b0;
      end
      req_valid = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      op_c = {$urandom, $urandom}; op_rm = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b0; req_valid = 2'b00; clr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
